// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the instruction ROM and imem_arbiter.
// The arbiter takes the slave side; requesters and the ROM sit on the master side.
interface imem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  rom_addr
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one combinational-read instruction ROM between fetch (fixed priority) and debug,
// with a starvation counter that forces a debug grant after STARVE_MAX denied cycles.
module imem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        OWN_FETCH = 1'b0,
        OWN_DEBUG = 1'b1
    } owner_e;

    localparam logic [CNT_W-1:0] SCNT_MAX = CNT_W'(STARVE_MAX);

    // Port 0 is fetch, port 1 is debug.
    logic [1:0]  req;
    logic [31:0] addr      [2];
    logic [31:0] word_addr [2];
    logic [1:0]  gnt;
    logic [1:0]  rvalid;

    logic        valid_q, valid_d;
    owner_e      owner_q, owner_d;
    logic [31:0] data_q,  data_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [31:0] rom_addr_d;

    assign req[0]  = bus.if_req;
    assign req[1]  = bus.dbg_req;
    assign addr[0] = bus.if_addr;
    assign addr[1] = bus.dbg_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign word_addr[gi] = {2'b00, addr[gi][31:2]};
            assign rvalid[gi]    = valid_q && (owner_q == owner_e'(1'(gi)));
        end
    endgenerate

    // Byte offset bits never reach the ROM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[0][1:0], addr[1][1:0]};

    // Grants are held off while reset is asserted so nothing is accepted then.
    always_comb begin
        gnt        = 2'b00;
        rom_addr_d = 32'd0;
        if (rst_n) begin
            if (req[0] && (!req[1] || (scnt_q < SCNT_MAX))) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
        if (gnt[0]) begin
            rom_addr_d = word_addr[0];
        end else if (gnt[1]) begin
            rom_addr_d = word_addr[1];
        end
    end

    always_comb begin
        valid_d = |gnt;
        owner_d = owner_q;
        data_d  = data_q;
        if (|gnt) begin
            data_d  = bus.rom_data;
            owner_d = gnt[1] ? OWN_DEBUG : OWN_FETCH;
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        if (!req[1] || gnt[1]) begin
            scnt_d = '0;
        end else if (scnt_q < SCNT_MAX) begin
            scnt_d = scnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            owner_q <= OWN_FETCH;
            data_q  <= 32'd0;
            scnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            scnt_q  <= scnt_d;
        end
    end

    assign bus.if_gnt     = gnt[0];
    assign bus.dbg_gnt    = gnt[1];
    assign bus.rom_addr   = rom_addr_d;
    assign bus.if_rvalid  = rvalid[0];
    assign bus.dbg_rvalid = rvalid[1];
    assign bus.if_rdata   = data_q;
    assign bus.dbg_rdata  = data_q;

endmodule
